// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU with fixed busy latency, MTHI/MTLO direct writes.
// Latency: MULT_LAT (mul) or DIV_LAT (div) busy cycles, then HI/LO update; MTHI/MTLO take effect on the accepting edge.
// Backpressure: start pulses arriving while busy (or with reserved ops) are dropped; the issuer must wait for busy=0.
module mult_div_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   hi_next_q, lo_next_q;
    logic [31:0]   hi_next_d, lo_next_d;

    logic [63:0]   a_sx, b_sx, prod_s, prod_u;
    logic          div_zero;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, q_s, r_s;
    logic [31:0]   den_u, q_u, r_u;

    assign busy = (cnt_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Result datapath: products and sign-magnitude division of the live operands.
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        a_sx     = {{32{rs_data[31]}}, rs_data};
        b_sx     = {{32{rt_data[31]}}, rt_data};
        prod_s   = a_sx * b_sx;
        prod_u   = {32'd0, rs_data} * {32'd0, rt_data};

        div_zero = (rt_data == 32'd0);
        a_mag    = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
        b_mag    = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
        if (div_zero) begin
            b_mag = 32'd1;
        end
        q_mag    = a_mag / b_mag;
        r_mag    = a_mag % b_mag;
        q_s      = (rs_data[31] ^ rt_data[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s      = rs_data[31] ? (~r_mag + 32'd1) : r_mag;

        den_u    = div_zero ? 32'd1 : rt_data;
        q_u      = rs_data / den_u;
        r_u      = rs_data % den_u;

        hi_next_d = hi_next_q;
        lo_next_d = lo_next_q;
        case (op)
            OP_MULT:  {hi_next_d, lo_next_d} = prod_s;
            OP_MULTU: {hi_next_d, lo_next_d} = prod_u;
            // Divide by zero retires the current HI/LO, which cannot change while busy.
            OP_DIV: begin
                hi_next_d = div_zero ? hi_q : r_s;
                lo_next_d = div_zero ? lo_q : q_s;
            end
            OP_DIVU: begin
                hi_next_d = div_zero ? hi_q : r_u;
                lo_next_d = div_zero ? lo_q : q_u;
            end
            default: ;
        endcase
    end

    // Request acceptance, busy countdown and HI/LO retirement; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_next_q <= 32'd0;
            lo_next_q <= 32'd0;
        end else if (busy) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_q <= hi_next_q;
                lo_q <= lo_next_q;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    hi_next_q <= hi_next_d;
                    lo_next_q <= lo_next_d;
                    cnt_q     <= CW'(MULT_LAT);
                end
                OP_DIV, OP_DIVU: begin
                    hi_next_q <= hi_next_d;
                    lo_next_q <= lo_next_d;
                    cnt_q     <= CW'(DIV_LAT);
                end
                OP_MTHI: hi_q <= rs_data;
                OP_MTLO: lo_q <= rs_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand sequences for reset and busy-time corners.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every wait on busy is bounded so the run always reaches its summary line.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    vec_t vecs[14];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge,
    // with operands scrambled so a late capture would corrupt the result.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = 4'd0;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Counts busy cycles while confirming HI/LO hold their old values.
    task automatic wait_done(input string name, input logic [31:0] ph, input logic [31:0] pl, output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            check32({name, "_hold_hi"}, hi, ph);
            check32({name, "_hold_lo"}, lo, pl);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] cur_hi, cur_lo;

        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{4'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{4'd5, 32'h00000011, 32'h12345678, 32'h00000011, 32'h80000000, 0};
        vecs[6]  = '{4'd6, 32'h00000022, 32'h12345678, 32'h00000011, 32'h00000022, 0};
        vecs[7]  = '{4'd4, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 10};
        vecs[8]  = '{4'd3, 32'h00000064, 32'h00000000, 32'h00000011, 32'h00000022, 10};
        vecs[9]  = '{4'd0, 32'h00000099, 32'h00000003, 32'h00000011, 32'h00000022, 0};
        vecs[10] = '{4'd9, 32'h00000099, 32'h00000003, 32'h00000011, 32'h00000022, 0};
        vecs[11] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[12] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[13] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        reset   = 1'b1;
        start   = 1'b0;
        op      = 4'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        repeat (3) @(negedge clk);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        reset = 1'b0;

        // Reset beats a simultaneous MTHI.
        issue(4'd5, 32'h00000005, 32'd0);
        check32("mthi_pre", hi, 32'h00000005);
        reset   = 1'b1;
        start   = 1'b1;
        op      = 4'd5;
        rs_data = 32'h000000AA;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        check32("rst_prio_hi", hi, 32'd0);
        check32("rst_prio_busy", {31'd0, busy}, 32'd0);

        cur_hi = 32'd0;
        cur_lo = 32'd0;
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), cur_hi, cur_lo, n);
            check32($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].ecyc));
            check32($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
            check32($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
            cur_hi = vecs[i].ehi;
            cur_lo = vecs[i].elo;
        end

        // Reset mid-divide aborts it with no late write, then a fresh MULT works.
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check32("abort_late_hi", hi, 32'd0);
        check32("abort_late_lo", lo, 32'd0);
        issue(4'd1, 32'd3, 32'd4);
        wait_done("post_abort", 32'd0, 32'd0, n);
        check32("post_abort_cycles", 32'(n), 32'd5);
        check32("post_abort_hi", hi, 32'd0);
        check32("post_abort_lo", lo, 32'd12);

        // MTLO during busy is dropped and operand changes do not leak into the product.
        issue(4'd1, 32'hFFFFFFFE, 32'h00000003);
        @(negedge clk);
        start   = 1'b1;
        op      = 4'd6;
        rs_data = 32'h0000DEAD;
        @(negedge clk);
        start   = 1'b0;
        op      = 4'd0;
        rs_data = 32'h00012345;
        rt_data = 32'h00000777;
        check32("mtlo_busy_lo", lo, 32'd12);
        wait_done("mtlo_busy", 32'd0, 32'd12, n);
        check32("mtlo_busy_cycles", 32'(n + 2), 32'd5);
        check32("mtlo_busy_hi", hi, 32'hFFFFFFFF);
        check32("mtlo_busy_res_lo", lo, 32'hFFFFFFFA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_LAT, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_LAT, default 10, busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request from E stage; qualifies op.
REQ-006 op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-15 reserved.
REQ-007 rs_data  input  32  operand A (multiplicand, dividend, or MTHI/MTLO source).
REQ-008 rt_data  input  32  operand B (multiplier, divisor).
REQ-009 busy  output  1  high while a multiply/divide is in flight.
REQ-010 hi  output  32  architectural HI register (registered).
REQ-011 lo  output  32  architectural LO register (registered).

Function
REQ-012 The block SHALL accept a request only on an edge where start=1, busy=0, reset=0 and op is 1-6; all other start pulses SHALL be ignored without side effects.
REQ-013 On acceptance of op 1-4, the block SHALL capture the result into internal hi_next/lo_next registers and load a down-counter with MULT_LAT (ops 1-2) or DIV_LAT (ops 3-4).
REQ-014 busy SHALL equal (counter != 0) as a registered value: busy rises on the edge that accepts the request and stays high for exactly MULT_LAT or DIV_LAT cycles.
REQ-015 On the edge where the counter goes 1 -> 0, hi/lo SHALL load hi_next/lo_next; busy is 0 in the following cycle, and hi/lo hold the new values in that cycle.
REQ-016 hi/lo SHALL NOT change during busy; MFHI/MFLO consumers read the old values until completion.
REQ-017 MULT: {hi,lo} = signed 32x32 -> 64 product; MULTU: unsigned product.
REQ-018 DIV: lo = quotient truncated toward zero, hi = remainder with the dividend's sign; DIVU: unsigned quotient/remainder.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-020 Divide by zero (rt_data=0, op 3 or 4) SHALL still run DIV_LAT busy cycles and SHALL leave hi/lo unchanged at completion.
REQ-021 MTHI/MTLO SHALL write rs_data into hi/lo on the accepting edge, with no busy cycles; the other register is unchanged.
REQ-022 start with any op while busy=1 (including MTHI/MTLO) SHALL be ignored; the in-flight operation completes unaffected.
REQ-023 Operand changes on rs_data/rt_data after the accepting edge SHALL NOT affect the result.
REQ-024 A new request SHALL be accepted in the first cycle where busy=0 after completion (back-to-back throughput = latency + 0 idle cycles).

Reset
REQ-025 With reset=1 at an edge, hi, lo, hi_next, lo_next and the counter SHALL clear to 0; busy SHALL be 0 in the following cycle.
REQ-026 Reset asserted mid-operation SHALL abort it; hi/lo SHALL remain 0 and no late write SHALL occur.
REQ-027 reset SHALL take priority over start on the same edge.

Verification
REQ-028 MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-029 DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=2 -> lo=3, hi=1.
REQ-030 hi=0x11, lo=0x22 preset via MTHI/MTLO; DIVU rt=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
REQ-031 MULT started, MTLO 0xDEAD pulsed at busy cycle 2, operands changed at cycle 3 -> MTLO ignored, result equals original operands' product.
REQ-032 DIV started, reset at busy cycle 4 -> busy=0 next cycle, hi=lo=0, no write at original completion edge; new MULT 3x4 then yields lo=12.
REQ-033 start with op=0 and op=9 -> busy stays 0, hi/lo unchanged; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
